// File: rtl/i2c_target_pkg.sv
// I2C target register bank: shared state encoding and bus constants.
// Imported by the top-level target FSM.
package i2c_target_pkg;

   // Byte-level protocol states of the target
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } state_t;

   // Level of the ninth (acknowledge) bit
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// I2C pad conditioner: 2-FF synchroniser, stable-count glitch filter,
// and one-cycle rise/fall flags aligned with the filtered level.
module i2c_line_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // Bring the asynchronous pad into the clk domain (idle bus is high)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   // Accept a new level only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= s2;
            cnt   <= '0;
            rise  <= s2;
            fall  <= ~s2;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register bank with an auto-incrementing
// register pointer; local logic reads the bank and sees every I2C write.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         REG_AW   = 4,
   parameter int         FILT_LEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   input  logic [REG_AW-1:0] loc_rd_addr,
   output logic [7:0]        loc_rd_data,
   output logic              wr_pulse,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int NREG = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk   (clk),
      .reset (reset),
      .pin   (scl_in),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk   (clk),
      .reset (reset),
      .pin   (sda_in),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   state_t            state;
   logic [7:0]        shift;
   logic [2:0]        bit_cnt;
   logic [REG_AW-1:0] ptr;
   logic              rw;
   logic              ack_seen;
   logic              mack;
   logic [7:0]        bank [NREG];

   logic       start_det;
   logic       stop_det;
   logic [7:0] nxt_byte;

   assign start_det   = sda_fall & scl_lvl;
   assign stop_det    = sda_rise & scl_lvl;
   assign nxt_byte    = {shift[6:0], sda_lvl};
   assign loc_rd_data = bank[loc_rd_addr];

   // Protocol FSM: bits sampled on SCL rise, SDA drive changed on SCL fall;
   // ack_seen marks that the ninth clock has risen inside an ACK state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         ptr      <= '0;
         rw       <= 1'b0;
         ack_seen <= 1'b0;
         mack     <= NACK;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_pulse <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < NREG; i++) bank[i] <= '0;
      end else begin
         wr_pulse <= 1'b0;
         if (start_det) begin
            state    <= ST_ADDR;
            bit_cnt  <= '0;
            ack_seen <= 1'b0;
            sda_oe   <= 1'b0;
         end else if (stop_det) begin
            state    <= ST_IDLE;
            ack_seen <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
         end else if (scl_rise) begin
            unique case (state)
               ST_ADDR: begin
                  shift   <= nxt_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (nxt_byte[7:1] == DEV_ADDR) begin
                        state    <= ST_ADDR_ACK;
                        rw       <= nxt_byte[0];
                        busy     <= 1'b1;
                        ack_seen <= 1'b0;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               ST_PTR: begin
                  shift   <= nxt_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr      <= nxt_byte[REG_AW-1:0];
                     state    <= ST_PTR_ACK;
                     ack_seen <= 1'b0;
                  end
               end
               ST_WDATA: begin
                  shift   <= nxt_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     bank[ptr] <= nxt_byte;
                     wr_pulse  <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= nxt_byte;
                     ptr       <= ptr + PTR_ONE;
                     state     <= ST_WDATA_ACK;
                     ack_seen  <= 1'b0;
                  end
               end
               ST_RDATA: begin
                  shift   <= {shift[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr      <= ptr + PTR_ONE;
                     state    <= ST_RDATA_ACK;
                     ack_seen <= 1'b0;
                  end
               end
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                  ack_seen <= 1'b1;
               end
               ST_RDATA_ACK: begin
                  ack_seen <= 1'b1;
                  mack     <= sda_lvl;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            unique case (state)
               ST_ADDR_ACK: begin
                  if (!ack_seen) begin
                     sda_oe <= 1'b1;
                  end else begin
                     ack_seen <= 1'b0;
                     bit_cnt  <= '0;
                     if (rw) begin
                        shift  <= bank[ptr];
                        sda_oe <= ~bank[ptr][7];
                        state  <= ST_RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_PTR;
                     end
                  end
               end
               ST_PTR_ACK, ST_WDATA_ACK: begin
                  if (!ack_seen) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe   <= 1'b0;
                     ack_seen <= 1'b0;
                     bit_cnt  <= '0;
                     state    <= ST_WDATA;
                  end
               end
               ST_RDATA: begin
                  sda_oe <= ~shift[7];
               end
               ST_RDATA_ACK: begin
                  if (!ack_seen) begin
                     sda_oe <= 1'b0;
                  end else begin
                     ack_seen <= 1'b0;
                     bit_cnt  <= '0;
                     if (mack == ACK) begin
                        shift  <= bank[ptr];
                        sda_oe <= ~bank[ptr][7];
                        state  <= ST_RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, open-drain bus model,
// write scoreboard checked on wr_pulse, read scoreboard checked per byte.
module tb_i2c_target_regs;

   localparam int Q = 12;

   logic       clk;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [3:0] loc_rd_addr;
   logic [7:0] loc_rd_data;
   logic       wr_pulse;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] wr_q [$];
   logic [7:0]  rd_q [$];
   logic [7:0]  model [16];

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_target_regs dut (
      .clk         (clk),
      .reset       (reset),
      .scl_in      (scl_in),
      .sda_in      (sda_in),
      .sda_oe      (sda_oe),
      .loc_rd_addr (loc_rd_addr),
      .loc_rd_data (loc_rd_data),
      .wr_pulse    (wr_pulse),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // write scoreboard: every wr_pulse must match the oldest expected write
   always @(negedge clk) begin
      if (!reset && wr_pulse) begin
         n_cmp++;
         if (wr_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected: got %h/%h, required no pulse",
                     wr_addr, wr_data);
         end else begin
            logic [11:0] e;
            e = wr_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               n_bad++;
               $display("FAIL wr_pulse: got %h/%h, required %h/%h",
                        wr_addr, wr_data, e[11:8], e[7:0]);
            end
         end
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = sda_in;   wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic mack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(mack);
   endtask

   task automatic test_reset();
      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; loc_rd_addr = '0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({sda_oe, wr_pulse, wr_addr, wr_data, busy} !== 15'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got oe%b wp%b a%h d%h b%b, required 0",
                  sda_oe, wr_pulse, wr_addr, wr_data, busy);
      end
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         model[i] = 8'h00;
         loc_rd_addr = 4'(i);
         @(negedge clk);
         n_cmp++;
         if (loc_rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_bank[%0d]: got %h, required 00",
                     i, loc_rd_data);
         end
      end
      wait_q();
   endtask

   task automatic test_write();
      logic [7:0] seq [4];
      logic ack;
      seq = '{8'h84, 8'h03, 8'hA5, 8'h5A};
      bus_start();
      for (int i = 0; i < 4; i++) begin
         if (i >= 2) begin
            wr_q.push_back({4'(i + 1), seq[i]});
            model[i + 1] = seq[i];
         end
         send_byte(seq[i], ack);
         n_cmp++;
         if (ack !== 1'b0) begin
            n_bad++;
            $display("FAIL write_ack[%0d]: got %b, required 0", i, ack);
         end
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL write_busy: got %b, required 1", busy);
      end
      bus_stop();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL write_busy_stop: got %b, required 0", busy);
      end
      for (int a = 3; a <= 4; a++) begin
         loc_rd_addr = 4'(a);
         @(negedge clk);
         n_cmp++;
         if (loc_rd_data !== model[a]) begin
            n_bad++;
            $display("FAIL write_bank[%0d]: got %h, required %h",
                     a, loc_rd_data, model[a]);
         end
      end
      n_cmp++;
      if (wr_q.size() != 0) begin
         n_bad++;
         $display("FAIL write_missing: %0d pulses outstanding, required 0",
                  wr_q.size());
      end
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] d;
      logic [7:0] e;
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h03, ack);
      bus_start();
      send_byte(8'h85, ack);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_bad++;
         $display("FAIL read_addr_ack: got %b, required 0", ack);
      end
      for (int i = 0; i < 2; i++) begin
         rd_q.push_back(model[3 + i]);
         recv_byte(d, (i == 1));
         e = rd_q.pop_front();
         n_cmp++;
         if (d !== e) begin
            n_bad++;
            $display("FAIL read_byte[%0d]: got %h, required %h", i, d, e);
         end
      end
      n_cmp++;
      if (sda_oe !== 1'b0) begin
         n_bad++;
         $display("FAIL read_nack_release: got oe %b, required 0", sda_oe);
      end
      bus_stop();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL read_busy_stop: got %b, required 0", busy);
      end
   endtask

   task automatic test_addr_miss();
      logic [7:0] seq [3];
      logic ack;
      seq = '{8'h90, 8'h00, 8'hFF};
      bus_start();
      for (int i = 0; i < 3; i++) begin
         send_byte(seq[i], ack);
         n_cmp++;
         if (ack !== 1'b1) begin
            n_bad++;
            $display("FAIL miss_ack[%0d]: got %b, required 1", i, ack);
         end
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL miss_busy: got %b, required 0", busy);
      end
      bus_stop();
      for (int a = 0; a < 16; a++) begin
         loc_rd_addr = 4'(a);
         @(negedge clk);
         n_cmp++;
         if (loc_rd_data !== model[a]) begin
            n_bad++;
            $display("FAIL miss_bank[%0d]: got %h, required %h",
                     a, loc_rd_data, model[a]);
         end
      end
   endtask

   task automatic test_wrap();
      logic ack;
      logic [7:0] d;
      logic [7:0] e;
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h01, ack);
      wr_q.push_back({4'h1, 8'h77}); model[1] = 8'h77;
      send_byte(8'h77, ack);
      bus_stop();
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h0F, ack);
      wr_q.push_back({4'hF, 8'h11}); model[15] = 8'h11;
      send_byte(8'h11, ack);
      wr_q.push_back({4'h0, 8'h22}); model[0] = 8'h22;
      send_byte(8'h22, ack);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_ack: got %b, required 0", ack);
      end
      bus_stop();
      loc_rd_addr = 4'hF;
      @(negedge clk);
      n_cmp++;
      if (loc_rd_data !== 8'h11) begin
         n_bad++;
         $display("FAIL wrap_bank15: got %h, required 11", loc_rd_data);
      end
      loc_rd_addr = 4'h0;
      @(negedge clk);
      n_cmp++;
      if (loc_rd_data !== 8'h22) begin
         n_bad++;
         $display("FAIL wrap_bank0: got %h, required 22", loc_rd_data);
      end
      bus_start();
      send_byte(8'h85, ack);
      rd_q.push_back(model[1]);
      recv_byte(d, 1'b1);
      e = rd_q.pop_front();
      n_cmp++;
      if (d !== e) begin
         n_bad++;
         $display("FAIL wrap_ptr_read: got %h, required %h", d, e);
      end
      bus_stop();
   endtask

   task automatic test_glitch();
      logic [7:0] b;
      logic ack;
      b = 8'h84;
      sda_m = 1'b0;
      repeat (2) @(negedge clk);
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b0;
      wait_q();
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(ack);
      n_cmp++;
      if (ack !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_no_start: got ack %b, required 1", ack);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_busy: got %b, required 0", busy);
      end
      bus_stop();
   endtask

   task automatic test_reset_mid_read();
      logic ack;
      logic [7:0] d;
      logic [7:0] e;
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h04, ack);
      bus_start();
      send_byte(8'h85, ack);
      n_cmp++;
      if (sda_oe !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre_oe: got %b, required 1", sda_oe);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (sda_oe !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async_oe: got %b, required 0", sda_oe);
      end
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if ({wr_pulse, wr_addr, wr_data, busy} !== 14'h0) begin
         n_bad++;
         $display("FAIL rst_outputs: got wp%b a%h d%h b%b, required 0",
                  wr_pulse, wr_addr, wr_data, busy);
      end
      for (int a = 0; a < 16; a++) model[a] = 8'h00;
      loc_rd_addr = 4'h4;
      @(negedge clk);
      n_cmp++;
      if (loc_rd_data !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_bank4: got %h, required 00", loc_rd_data);
      end
      reset = 1'b0;
      wait_q();
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h02, ack);
      wr_q.push_back({4'h2, 8'h3C}); model[2] = 8'h3C;
      send_byte(8'h3C, ack);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_next_ack: got %b, required 0", ack);
      end
      bus_stop();
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h02, ack);
      bus_start();
      send_byte(8'h85, ack);
      rd_q.push_back(model[2]);
      recv_byte(d, 1'b1);
      e = rd_q.pop_front();
      n_cmp++;
      if (d !== e) begin
         n_bad++;
         $display("FAIL rst_next_read: got %h, required %h", d, e);
      end
      bus_stop();
      n_cmp++;
      if (wr_q.size() != 0) begin
         n_bad++;
         $display("FAIL rst_missing: %0d pulses outstanding, required 0",
                  wr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_addr_miss();
      test_wrap();
      test_glitch();
      test_reset_mid_read();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
